// File: rtl/adc_scan_router_if.sv
`default_nettype none
// ============================================================================
// adc_scan_router_if - control, ADC handshake and sample bus of adc_scan_router
// Rev 1.0
// ============================================================================
interface adc_scan_router_if #(
  parameter int ADC_BITS = 10,
  parameter int W        = 24,
  parameter int NCH      = 3,
  parameter int SEL_BITS = 2
);
  logic                scan_en;
  logic [NCH-1:0]      ch_mask;
  logic [ADC_BITS-1:0] adc_code;
  logic                adc_valid;
  logic                adc_start;
  logic [SEL_BITS-1:0] mux_sel;
  logic [NCH*W-1:0]    ch_sample;
  logic [NCH-1:0]      ch_valid;
  logic                busy;
  logic                timeout_err;

  // master: the environment driving the router and playing the ADC front-end
  modport master (
    output scan_en, ch_mask, adc_code, adc_valid,
    input  adc_start, mux_sel, ch_sample, ch_valid, busy, timeout_err
  );

  modport slave (
    input  scan_en, ch_mask, adc_code, adc_valid,
    output adc_start, mux_sel, ch_sample, ch_valid, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/adc_scan_router.sv
`default_nettype none
// ============================================================================
// adc_scan_router - round-robin ADC mux scan, offset-binary to Q-format, block
// averaging. Optional conversion watchdog: define ADC_SCAN_TIMEOUT_EN. Rev 1.0
// ============================================================================
module adc_scan_router #(
  parameter int ADC_BITS = 10,
  parameter int W        = 24,
  parameter int FRAC     = 12,
  parameter int NCH      = 3,
  parameter int SEL_BITS = 2,
  parameter int SETTLE   = 4,
  parameter int AVG_LOG2 = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_scan_router_if.slave bus
);

  localparam int c_acc_w    = ADC_BITS + 1 + AVG_LOG2;
  localparam int c_cnt_w    = AVG_LOG2 + 1;
  localparam int c_settle_w = $clog2(SETTLE + 1);
  localparam logic [ADC_BITS:0]     c_offset      = {1'b0, 1'b1, {(ADC_BITS-1){1'b0}}};
  localparam logic [c_cnt_w-1:0]    c_last_conv   = c_cnt_w'((2 ** AVG_LOG2) - 1);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE - 1);

  if (SETTLE < 1 || TIMEOUT < 1 || NCH < 1 || NCH > 2 ** SEL_BITS ||
      AVG_LOG2 < 0 || AVG_LOG2 > 4 || W < ADC_BITS + 1 + FRAC) begin : g_param_check
    $error("adc_scan_router: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SWITCH  = 2'd1,
    S_CONVERT = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [c_settle_w-1:0]     r_settle;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      r_done;
  logic signed [c_acc_w-1:0] r_acc;
  logic [SEL_BITS-1:0]       r_last_ch;
  logic [SEL_BITS-1:0]       r_mux_sel;
  logic                      r_adc_start;
  logic [NCH-1:0]            r_ch_valid;
  logic [W-1:0]              r_sample [NCH];
  logic                      r_busy;

  logic                      w_go;
  logic                      w_select;
  logic                      w_start;
  logic                      w_accept;
  logic                      w_emit;
  logic                      w_abort;
  logic                      w_wd_hit;
  logic [SEL_BITS-1:0]       w_next_ch;
  logic [SEL_BITS-1:0]       w_hi_ch;
  logic [SEL_BITS-1:0]       w_lo_ch;
  logic                      w_hi_found;
  logic [ADC_BITS:0]         w_s;
  logic signed [c_acc_w-1:0] w_s_ext;
  logic signed [c_acc_w-1:0] w_avg_full;
  logic signed [ADC_BITS:0]  w_avg;
  logic [W-1:0]              w_q;

  assign w_go = bus.scan_en & (|bus.ch_mask);

  // Smallest enabled index above the last-served one, else the smallest overall.
  always_comb begin
    w_hi_ch    = '0;
    w_lo_ch    = '0;
    w_hi_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.ch_mask[k]) begin
        if (k > int'(r_last_ch)) begin
          w_hi_ch    = SEL_BITS'(k);
          w_hi_found = 1'b1;
        end else begin
          w_lo_ch = SEL_BITS'(k);
        end
      end
    end
    w_next_ch = w_hi_found ? w_hi_ch : w_lo_ch;
  end

  assign w_s        = {1'b0, bus.adc_code} - c_offset;
  assign w_s_ext    = c_acc_w'($signed(w_s));
  assign w_avg_full = r_acc >>> AVG_LOG2;
  assign w_avg      = w_avg_full[ADC_BITS:0];
  assign w_q        = W'(w_avg) << FRAC;

  always_comb begin
    w_next_state = r_state;
    w_select     = 1'b0;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_emit       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next_state = S_SWITCH;
          w_select     = 1'b1;
        end
      end
      S_SWITCH: begin
        if (r_settle == c_settle_last) begin
          w_next_state = S_CONVERT;
          w_start      = 1'b1;
        end
      end
      S_CONVERT: begin
        // r_done spends one cycle after the final sample before EMIT.
        if (r_done) begin
          w_next_state = S_EMIT;
        end else if (bus.adc_valid && !r_adc_start) begin
          w_accept = 1'b1;
          w_start  = (r_cnt != c_last_conv);
        end else if (w_wd_hit) begin
          w_abort = 1'b1;
          if (w_go) begin
            w_next_state = S_SWITCH;
            w_select     = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        w_emit = 1'b1;
        if (w_go) begin
          w_next_state = S_SWITCH;
          w_select     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_settle    <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_acc       <= '0;
      r_last_ch   <= SEL_BITS'(NCH - 1);
      r_mux_sel   <= '0;
      r_adc_start <= 1'b0;
      r_ch_valid  <= '0;
      r_busy      <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_sample[k] <= '0;
      end
    end else begin
      r_state     <= w_next_state;
      r_adc_start <= w_start;
      r_busy      <= (r_state != S_IDLE);

      if (w_select) begin
        r_last_ch <= w_next_ch;
        r_mux_sel <= w_next_ch;
        r_settle  <= '0;
      end else if (r_state == S_SWITCH) begin
        r_settle <= r_settle + 1'b1;
      end

      if (w_emit || w_abort) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (w_accept) begin
        r_acc <= r_acc + w_s_ext;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_last_conv) begin
          r_done <= 1'b1;
        end
      end

      for (int k = 0; k < NCH; k++) begin
        r_ch_valid[k] <= w_emit && (r_last_ch == SEL_BITS'(k));
        if (w_emit && (r_last_ch == SEL_BITS'(k))) begin
          r_sample[k] <= w_q;
        end
      end
    end
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT + 1);

  logic [c_wd_w-1:0] r_wd;
  logic              r_timeout_err;

  // Counts CONVERT cycles since the latest adc_start.
  assign w_wd_hit = (r_wd == c_wd_w'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_wd <= '0;
      end else if (r_state == S_CONVERT) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_wd_hit        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.adc_start = r_adc_start;
  assign bus.mux_sel   = r_mux_sel;
  assign bus.ch_valid  = r_ch_valid;
  assign bus.busy      = r_busy;

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign bus.ch_sample[k*W +: W] = r_sample[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_router.sv
`default_nettype none
// ============================================================================
// tb_adc_scan_router - directed bench: instance A (no averaging), B (4x average)
// Rev 1.0
// ============================================================================
module tb_adc_scan_router;

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam logic c_exp_terr = 1'b1;
`else
  localparam logic c_exp_terr = 1'b0;
`endif
  localparam int c_lat = 2;

  logic clk;
  logic rst_n;

  adc_scan_router_if #(.ADC_BITS(10), .W(24), .NCH(3), .SEL_BITS(2)) bus_a ();
  adc_scan_router_if #(.ADC_BITS(10), .W(24), .NCH(3), .SEL_BITS(2)) bus_b ();

  adc_scan_router #(.AVG_LOG2(0)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  adc_scan_router #(.AVG_LOG2(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  logic       adc_on_a, adc_on_b;
  logic       mdl_valid_a, mdl_valid_b, inj_valid_a;
  logic [9:0] mdl_code_a, mdl_code_b, inj_code_a;
  int         pend_a, pend_b, nb;
  int         st_a = 0, st_b = 0, cvn_a = 0, seen1 = 0, mb_bad = 0;
  logic       mon_mux1;

  assign bus_a.adc_valid = mdl_valid_a | inj_valid_a;
  assign bus_a.adc_code  = inj_valid_a ? inj_code_a : mdl_code_a;
  assign bus_b.adc_valid = mdl_valid_b;
  assign bus_b.adc_code  = mdl_code_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // sel: 0 A ch_valid, 1 A adc_start, 2 B ch_valid, 3 B adc_start
  task automatic wait_event(input int sel, input int budget, output int dt);
    logic hit;
    dt  = 0;
    hit = 1'b0;
    while (!hit && dt < budget) begin
      @(negedge clk);
      dt++;
      case (sel)
        0:       hit = |bus_a.ch_valid;
        1:       hit = bus_a.adc_start;
        2:       hit = |bus_b.ch_valid;
        default: hit = bus_b.adc_start;
      endcase
    end
    check_val($sformatf("wait%0d_hit", sel), {31'd0, hit}, 32'd1);
  endtask

  // ADC models: fixed latency c_lat from adc_start to a one-cycle adc_valid.
  initial begin
    mdl_valid_a = 1'b0;
    mdl_code_a  = '0;
    pend_a      = 0;
    forever begin
      @(posedge clk);
      #1;
      mdl_valid_a = 1'b0;
      if (!rst_n) begin
        pend_a = 0;
      end else begin
        if (pend_a > 0) begin
          pend_a--;
          if (pend_a == 0) begin
            mdl_valid_a = 1'b1;
            case (bus_a.mux_sel)
              2'd0:    mdl_code_a = 10'd512;
              2'd1:    mdl_code_a = 10'd1023;
              default: mdl_code_a = 10'd0;
            endcase
          end
        end
        if (bus_a.adc_start && adc_on_a) pend_a = c_lat;
      end
    end
  end

  initial begin
    mdl_valid_b = 1'b0;
    mdl_code_b  = '0;
    pend_b      = 0;
    forever begin
      @(posedge clk);
      #1;
      mdl_valid_b = 1'b0;
      if (!rst_n) begin
        pend_b = 0;
      end else begin
        if (pend_b > 0) begin
          pend_b--;
          if (pend_b == 0) begin
            mdl_valid_b = 1'b1;
            mdl_code_b  = 10'(600 + nb);
            nb++;
          end
        end
        if (bus_b.adc_start && adc_on_b) pend_b = c_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (bus_a.adc_start) st_a <= st_a + 1;
    if (bus_b.adc_start) st_b <= st_b + 1;
    if (|bus_a.ch_valid) cvn_a <= cvn_a + 1;
    if (mon_mux1 && bus_a.mux_sel == 2'd1) seen1 <= seen1 + 1;
    if (bus_b.busy && bus_b.mux_sel != 2'd1) mb_bad <= mb_bad + 1;
  end

  initial begin
    int dt;
    int snap;
    rst_n         = 1'b0;
    adc_on_a      = 1'b0;
    adc_on_b      = 1'b0;
    inj_valid_a   = 1'b0;
    inj_code_a    = '0;
    nb            = 0;
    mon_mux1      = 1'b0;
    bus_a.scan_en = 1'b0;
    bus_a.ch_mask = '0;
    bus_b.scan_en = 1'b0;
    bus_b.ch_mask = '0;

    repeat (3) @(negedge clk);
    check_val("rst_mux",    {30'd0, bus_a.mux_sel}, 32'd0);
    check_val("rst_start",  {31'd0, bus_a.adc_start}, 32'd0);
    check_val("rst_cv",     {29'd0, bus_a.ch_valid}, 32'd0);
    check_val("rst_busy",   {31'd0, bus_a.busy}, 32'd0);
    check_val("rst_terr",   {31'd0, bus_a.timeout_err}, 32'd0);
    check_val("rst_sample", {31'd0, |bus_a.ch_sample}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray adc_valid while IDLE
    inj_code_a  = 10'd1023;
    inj_valid_a = 1'b1;
    @(negedge clk);
    inj_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_inj_cv",   {29'd0, bus_a.ch_valid}, 32'd0);
    check_val("idle_inj_busy", {31'd0, bus_a.busy}, 32'd0);

    // Full scan x,y,z on A
    adc_on_a      = 1'b1;
    bus_a.ch_mask = 3'b111;
    bus_a.scan_en = 1'b1;
    @(negedge clk);
    check_val("sw_busy_lag", {31'd0, bus_a.busy}, 32'd0);
    inj_valid_a = 1'b1;  // lands in SWITCH
    @(negedge clk);
    inj_valid_a = 1'b0;
    check_val("busy_up", {31'd0, bus_a.busy}, 32'd1);
    wait_event(1, 20, dt);
    check_val("start_lat", dt, 32'd3);
    wait_event(0, 40, dt);
    check_val("cv0_lat", dt, 32'd5);
    check_val("cv0_bit", {29'd0, bus_a.ch_valid}, 32'd1);
    check_val("cv0_smp", {8'd0, bus_a.ch_sample[23:0]}, 32'h000000);
    check_val("cv0_nextmux", {30'd0, bus_a.mux_sel}, 32'd1);
    @(negedge clk);
    check_val("cv_pulse", {29'd0, bus_a.ch_valid}, 32'd0);
    wait_event(0, 40, dt);
    check_val("cv1_period", dt, 32'd8);
    check_val("cv1_bit", {29'd0, bus_a.ch_valid}, 32'd2);
    check_val("cv1_smp", {8'd0, bus_a.ch_sample[47:24]}, 32'h1FF000);
    wait_event(0, 40, dt);
    check_val("cv2_period", dt, 32'd9);
    check_val("cv2_bit", {29'd0, bus_a.ch_valid}, 32'd4);
    check_val("cv2_smp", {8'd0, bus_a.ch_sample[71:48]}, 32'hE00000);

    // Mask 101, then stop during the channel-2 conversion
    bus_a.ch_mask = 3'b101;
    mon_mux1      = 1'b1;
    wait_event(0, 40, dt);
    check_val("m101_cv0", {29'd0, bus_a.ch_valid}, 32'd1);
    check_val("m101_skip", {30'd0, bus_a.mux_sel}, 32'd2);
    wait_event(1, 20, dt);
    check_val("m101_start", dt, 32'd4);
    bus_a.scan_en = 1'b0;
    wait_event(0, 40, dt);
    check_val("stop_cv2_lat", dt, 32'd5);
    check_val("stop_cv2_bit", {29'd0, bus_a.ch_valid}, 32'd4);
    check_val("stop_busy_hi", {31'd0, bus_a.busy}, 32'd1);
    @(negedge clk);
    check_val("stop_busy_fall", {31'd0, bus_a.busy}, 32'd0);
    #1 snap = st_a;
    repeat (20) @(negedge clk);
    #1;
    check_val("stop_no_start", st_a - snap, 32'd0);
    check_val("m101_no_mux1", seen1, 32'd0);
    mon_mux1 = 1'b0;

    // Silent ADC: CONVERT never completes without the watchdog
    adc_on_a      = 1'b0;
    bus_a.ch_mask = 3'b010;
    bus_a.scan_en = 1'b1;
    wait_event(1, 20, dt);
    #1 snap = cvn_a;
    repeat (300) @(negedge clk);
    #1;
    check_val("silent_cv", cvn_a - snap, 32'd0);
    check_val("silent_busy", {31'd0, bus_a.busy}, 32'd1);
    check_val("silent_mux", {30'd0, bus_a.mux_sel}, 32'd1);
    check_val("silent_terr", {31'd0, bus_a.timeout_err}, {31'd0, c_exp_terr});

    // Asynchronous reset mid-CONVERT, away from any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy",   {31'd0, bus_a.busy}, 32'd0);
    check_val("arst_mux",    {30'd0, bus_a.mux_sel}, 32'd0);
    check_val("arst_sample", {31'd0, |bus_a.ch_sample}, 32'd0);
    check_val("arst_terr",   {31'd0, bus_a.timeout_err}, 32'd0);
    check_val("arst_start",  {31'd0, bus_a.adc_start}, 32'd0);
    bus_a.scan_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // B: 4-sample average on channel 1, scan_en dropped after the first start
    adc_on_b      = 1'b1;
    bus_b.ch_mask = 3'b010;
    #1 snap = st_b;
    bus_b.scan_en = 1'b1;
    wait_event(3, 20, dt);
    check_val("avg_start_lat", dt, 32'd5);
    check_val("avg_mux", {30'd0, bus_b.mux_sel}, 32'd1);
    bus_b.scan_en = 1'b0;
    wait_event(2, 60, dt);
    check_val("avg_cv_lat", dt, 32'd14);
    check_val("avg_cv_bit", {29'd0, bus_b.ch_valid}, 32'd2);
    check_val("avg_smp", {8'd0, bus_b.ch_sample[47:24]}, 32'h059000);
    @(negedge clk);
    check_val("avg_busy_fall", {31'd0, bus_b.busy}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check_val("avg_starts", st_b - snap, 32'd4);
    check_val("avg_mux_held", mb_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
